// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem req/gnt/rvalid bus, execute redirect and decode valid/ready handshake bundled for fetch_unit
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, imem word requests, response FIFO to decode with redirect flush/squash; ports clk, rst_n (sync active-low), bus (fetch_unit_if.master)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] fpc, resp_pc;
  logic [CW-1:0] outstanding, squash_cnt, count;
  logic [PW-1:0] wptr, rptr;
  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc [DEPTH];
  logic credit, grant, rv, push, pop, nonempty;
  logic [CW:0] used;
  always_comb begin
    used = {1'b0, outstanding} + {1'b0, count};
    credit = used < (CW+1)'(DEPTH);
    nonempty = count != '0;
    rv = bus.imem_rvalid & (outstanding != '0);
    grant = bus.imem_req & bus.imem_gnt;
    push = rv & (squash_cnt == '0) & ~bus.redirect_valid;
    pop = bus.instr_valid & bus.instr_ready;
  end
  assign bus.imem_req = rst_n & credit & ~bus.redirect_valid;
  assign bus.imem_addr = fpc;
  assign bus.instr_valid = nonempty & ~bus.redirect_valid;
  assign bus.instr = nonempty ? fifo_instr[rptr] : NOP;
  assign bus.instr_pc = nonempty ? fifo_pc[rptr] : 32'h0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      squash_cnt <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else if (bus.redirect_valid) begin
      fpc <= {bus.redirect_pc[31:2], 2'b00};
      resp_pc <= {bus.redirect_pc[31:2], 2'b00};
      outstanding <= outstanding - CW'(rv);
      squash_cnt <= outstanding - CW'(rv);
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      fpc <= grant ? fpc + 32'd4 : fpc;
      outstanding <= outstanding + CW'(grant) - CW'(rv);
      squash_cnt <= (rv && squash_cnt != '0) ? squash_cnt - 1'b1 : squash_cnt;
      count <= count + CW'(push) - CW'(pop);
      if (push) begin
        fifo_instr[wptr] <= bus.imem_rdata;
        fifo_pc[wptr] <= resp_pc;
        resp_pc <= resp_pc + 32'd4;
        wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a queue-level fetch/memory model
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] addr; bit sq;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  mreq_t mem_q[$];
  exp_t exp_q[$];
  logic [31:0] mdl_fpc = RESET_PC;
  int n_chk = 0;
  int n_fail = 0;
  bit was_rst = 1'b1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    bit ereq, evld;
    mreq_t m;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      if (was_rst) begin
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, NOP);
        chk("rst_pc", bus.instr_pc, 32'd0);
      end
      mem_q.delete();
      exp_q.delete();
      mdl_fpc = RESET_PC;
    end else begin
      ereq = (mem_q.size() + exp_q.size() < DEPTH) && !bus.redirect_valid;
      evld = exp_q.size() > 0 && !bus.redirect_valid;
      chk("req", {31'b0, bus.imem_req}, {31'b0, ereq});
      if (ereq) chk("addr", bus.imem_addr, mdl_fpc);
      chk("valid", {31'b0, bus.instr_valid}, {31'b0, evld});
      if (exp_q.size() > 0) begin
        chk("instr", bus.instr, exp_q[0].ins);
        chk("instr_pc", bus.instr_pc, exp_q[0].pc);
      end else begin
        chk("empty_instr", bus.instr, NOP);
        chk("empty_pc", bus.instr_pc, 32'd0);
      end
      if (bus.redirect_valid) begin
        if (bus.imem_rvalid) void'(mem_q.pop_front());
        foreach (mem_q[i]) mem_q[i].sq = 1'b1;
        exp_q.delete();
        mdl_fpc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (evld && bus.instr_ready) void'(exp_q.pop_front());
        if (bus.imem_rvalid) begin
          m = mem_q.pop_front();
          if (!m.sq) exp_q.push_back('{m.addr, m.addr ^ K});
        end
        if (ereq && bus.imem_gnt) begin
          mem_q.push_back('{mdl_fpc, 1'b0});
          mdl_fpc += 32'd4;
        end
      end
    end
    was_rst = !rst_n;
  end
  task automatic run(int n, bit rst, int pg, int prv, int prdy, int prd, logic [31:0] rpc, bit rnd);
    repeat (n) begin
      @(negedge clk);
      rst_n = !rst;
      bus.imem_gnt = $urandom_range(99) < pg;
      bus.imem_rvalid = !rst && mem_q.size() > 0 && $urandom_range(99) < prv;
      bus.imem_rdata = bus.imem_rvalid ? mem_q[0].addr ^ K : $urandom;
      bus.instr_ready = $urandom_range(99) < prdy;
      bus.redirect_valid = !rst && $urandom_range(99) < prd;
      bus.redirect_pc = rnd ? $urandom : rpc;
    end
  endtask
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
    run(2, 1, 0, 0, 0, 0, 0, 0);
    run(30, 0, 100, 100, 100, 0, 0, 0);
    run(10, 0, 100, 100, 0, 0, 0, 0);
    run(10, 0, 100, 100, 100, 0, 0, 0);
    run(2, 0, 100, 0, 100, 0, 0, 0);
    run(1, 0, 100, 0, 100, 100, 32'h100, 0);
    run(12, 0, 100, 100, 100, 0, 0, 0);
    run(1, 0, 100, 100, 100, 100, 32'h203, 0);
    run(8, 0, 100, 100, 100, 0, 0, 0);
    run(1, 0, 100, 100, 100, 100, 32'hFFFF_FFF3, 0);
    run(10, 0, 100, 100, 100, 0, 0, 0);
    run(5, 0, 0, 100, 100, 0, 0, 0);
    run(4, 0, 100, 100, 100, 0, 0, 0);
    run(2, 0, 100, 0, 0, 0, 0, 0);
    run(1, 0, 0, 100, 0, 0, 0, 0);
    run(1, 0, 0, 100, 100, 100, 32'h300, 0);
    run(10, 0, 100, 100, 100, 0, 0, 0);
    run(3, 1, 100, 100, 100, 0, 0, 0);
    run(10, 0, 100, 100, 100, 0, 0, 0);
    repeat (40) run(50, 0, $urandom_range(100), $urandom_range(100), $urandom_range(100), 5, 0, 1);
    run(2, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
